// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the serial word transmitter and its matching receiver.
// Holds the FSM encoding, the common word width and a counter-width helper.
package serial_word_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } tx_state_t;

   localparam int WORD_WIDTH          = 32;
   localparam int DEFAULT_HALF_PERIOD = 51;

   // Counter width for n distinct values, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Free-running bit-period timer: produces the registered bit clock and a
// one-cycle strobe in the cycle where the phase counter wraps to zero.
module serial_bit_timer
   import serial_word_tx_pkg::*;
#(
   parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
   input  logic clk,
   input  logic reset,
   output logic bclk,
   output logic strobe
);

   localparam int            PW         = cnt_width(2 * HALF_PERIOD);
   localparam logic [PW-1:0] PHASE_LAST = PW'(2 * HALF_PERIOD - 1);
   localparam logic [PW-1:0] PHASE_HIGH = PW'(HALF_PERIOD);

   logic [PW-1:0] phase_r;
   logic [PW-1:0] phase_next_s;
   logic          bclk_r;

   // Phase advance with wrap at the end of the bit period.
   always_comb begin
      if (phase_r == PHASE_LAST) begin
         phase_next_s = {PW{1'b0}};
      end else begin
         phase_next_s = phase_r + PW'(1);
      end
   end

   // bclk is decoded from the next phase so it stays aligned with phase_r.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_r <= {PW{1'b0}};
         bclk_r  <= 1'b0;
      end else begin
         phase_r <= phase_next_s;
         bclk_r  <= (phase_next_s >= PHASE_HIGH);
      end
   end

   assign bclk   = bclk_r;
   assign strobe = (phase_r == PHASE_LAST);

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: accepts a word on a valid/ready
// handshake and shifts it MSB-first, framed by com_en, on bit boundaries.
module serial_word_tx
   import serial_word_tx_pkg::*;
#(
   parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
   parameter int WIDTH       = WORD_WIDTH,
   parameter int GAP_BITS    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             send,
   output logic             ready,
   output logic             sdata,
   output logic             com_en,
   output logic             bclk,
   output logic             done
);

   localparam int            BW       = cnt_width(WIDTH);
   localparam int            GW       = cnt_width(GAP_BITS + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   tx_state_t        state_r;
   tx_state_t        state_next_s;
   logic [WIDTH-1:0] shreg_r;
   logic [WIDTH-1:0] shreg_next_s;
   logic [BW-1:0]    bitcnt_r;
   logic [BW-1:0]    bitcnt_next_s;
   logic [GW-1:0]    gapcnt_r;
   logic [GW-1:0]    gapcnt_next_s;
   logic             sdata_r;
   logic             sdata_next_s;
   logic             com_en_r;
   logic             com_en_next_s;
   logic             done_r;
   logic             done_next_s;
   logic             ready_r;
   logic             ready_next_s;
   logic             strobe_s;
   logic             accept_s;

   serial_bit_timer #(
      .HALF_PERIOD(HALF_PERIOD)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .bclk  (bclk),
      .strobe(strobe_s)
   );

   assign accept_s = send && ready_r;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; every transition after acceptance waits for a boundary.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_next_s = ST_ARMED;
            else          state_next_s = ST_IDLE;
         end
         ST_ARMED: begin
            if (strobe_s) state_next_s = ST_SHIFT;
            else          state_next_s = ST_ARMED;
         end
         ST_SHIFT: begin
            if (strobe_s && (bitcnt_r == BIT_LAST)) state_next_s = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
            else                                    state_next_s = ST_SHIFT;
         end
         ST_GAP: begin
            if (strobe_s && (gapcnt_r == GAP_LAST)) state_next_s = ST_IDLE;
            else                                    state_next_s = ST_GAP;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      shreg_next_s  = shreg_r;
      bitcnt_next_s = bitcnt_r;
      gapcnt_next_s = gapcnt_r;
      sdata_next_s  = sdata_r;
      com_en_next_s = com_en_r;
      ready_next_s  = ready_r;
      done_next_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               shreg_next_s = data_in;
               ready_next_s = 1'b0;
            end else begin
               ready_next_s = 1'b1;
            end
         end
         ST_ARMED: begin
            if (strobe_s) begin
               com_en_next_s = 1'b1;
               sdata_next_s  = shreg_r[WIDTH-1];
               shreg_next_s  = {shreg_r[WIDTH-2:0], 1'b0};
               bitcnt_next_s = {BW{1'b0}};
            end else begin
               com_en_next_s = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (strobe_s) begin
               if (bitcnt_r == BIT_LAST) begin
                  com_en_next_s = 1'b0;
                  sdata_next_s  = 1'b0;
                  done_next_s   = 1'b1;
                  gapcnt_next_s = {GW{1'b0}};
                  ready_next_s  = (GAP_BITS == 0);
               end else begin
                  sdata_next_s  = shreg_r[WIDTH-1];
                  shreg_next_s  = {shreg_r[WIDTH-2:0], 1'b0};
                  bitcnt_next_s = bitcnt_r + BW'(1);
               end
            end else begin
               com_en_next_s = 1'b1;
            end
         end
         ST_GAP: begin
            if (strobe_s) begin
               if (gapcnt_r == GAP_LAST) begin
                  ready_next_s = 1'b1;
               end else begin
                  gapcnt_next_s = gapcnt_r + GW'(1);
               end
            end else begin
               com_en_next_s = 1'b0;
            end
         end
         default: begin
            com_en_next_s = 1'b0;
            sdata_next_s  = 1'b0;
            ready_next_s  = 1'b1;
         end
      endcase
   end

   // Datapath and output registers; reset drops the frame immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_r  <= {WIDTH{1'b0}};
         bitcnt_r <= {BW{1'b0}};
         gapcnt_r <= {GW{1'b0}};
         sdata_r  <= 1'b0;
         com_en_r <= 1'b0;
         done_r   <= 1'b0;
         ready_r  <= 1'b1;
      end else begin
         shreg_r  <= shreg_next_s;
         bitcnt_r <= bitcnt_next_s;
         gapcnt_r <= gapcnt_next_s;
         sdata_r  <= sdata_next_s;
         com_en_r <= com_en_next_s;
         done_r   <= done_next_s;
         ready_r  <= ready_next_s;
      end
   end

   assign sdata  = sdata_r;
   assign com_en = com_en_r;
   assign done   = done_r;
   assign ready  = ready_r;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: a bclk-driven receiver model per instance feeds
// a received-word queue that is checked against an expected-word scoreboard.
module tb_serial_word_tx;

   localparam int HP = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Instance a: GAP_BITS=2, instance b: GAP_BITS=0.
   logic        reset_a = 1'b0, send_a = 1'b0;
   logic [31:0] data_a  = 32'h0;
   logic        ready_a, sdata_a, com_en_a, bclk_a, done_a;
   logic        reset_b = 1'b0, send_b = 1'b0;
   logic [31:0] data_b  = 32'h0;
   logic        ready_b, sdata_b, com_en_b, bclk_b, done_b;

   serial_word_tx #(.HALF_PERIOD(HP), .WIDTH(32), .GAP_BITS(2)) dut_a (
      .clk(clk), .reset(reset_a), .data_in(data_a), .send(send_a), .ready(ready_a),
      .sdata(sdata_a), .com_en(com_en_a), .bclk(bclk_a), .done(done_a));

   serial_word_tx #(.HALF_PERIOD(HP), .WIDTH(32), .GAP_BITS(0)) dut_b (
      .clk(clk), .reset(reset_b), .data_in(data_b), .send(send_b), .ready(ready_b),
      .sdata(sdata_b), .com_en(com_en_b), .bclk(bclk_b), .done(done_b));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] exp_a[$], exp_b[$], rx_a[$], rx_b[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver model and frame statistics for instance a.
   logic [31:0] rxa_sh = 32'h0;
   int          rxa_cnt = 0, run_a = 0, last_run_a = 0, done_cnt_a = 0, coin_a = 0, fall_a = 0, rise_a = 0;
   logic        bclk_a_prev = 1'b0, com_a_prev = 1'b0, rdy_a_prev = 1'b0;
   always @(negedge clk) begin
      bclk_a_prev <= bclk_a;
      com_a_prev  <= com_en_a;
      rdy_a_prev  <= ready_a;
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (com_en_a) run_a <= run_a + 1;
      else if (run_a != 0) begin last_run_a <= run_a; run_a <= 0; end
      if (com_a_prev && !com_en_a) fall_a <= cyc;
      if (ready_a && !rdy_a_prev) rise_a <= cyc;
      if (done_a && ready_a && !rdy_a_prev) coin_a <= coin_a + 1;
      if (!com_en_a) begin
         rxa_cnt <= 0;
         rxa_sh  <= 32'h0;
      end else if (bclk_a && !bclk_a_prev) begin
         if (rxa_cnt == 31) begin
            rx_a.push_back({rxa_sh[30:0], sdata_a});
            rxa_cnt <= 0;
         end else begin
            rxa_cnt <= rxa_cnt + 1;
            rxa_sh  <= {rxa_sh[30:0], sdata_a};
         end
      end
   end

   // Receiver model and frame statistics for instance b.
   logic [31:0] rxb_sh = 32'h0;
   int          rxb_cnt = 0, low_b = 0, last_low_b = 0, coin_b = 0;
   logic        bclk_b_prev = 1'b0, rdy_b_prev = 1'b0;
   always @(negedge clk) begin
      bclk_b_prev <= bclk_b;
      rdy_b_prev  <= ready_b;
      if (!com_en_b) low_b <= low_b + 1;
      else if (low_b != 0) begin last_low_b <= low_b; low_b <= 0; end
      if (done_b && ready_b && !rdy_b_prev) coin_b <= coin_b + 1;
      if (!com_en_b) begin
         rxb_cnt <= 0;
         rxb_sh  <= 32'h0;
      end else if (bclk_b && !bclk_b_prev) begin
         if (rxb_cnt == 31) begin
            rx_b.push_back({rxb_sh[30:0], sdata_b});
            rxb_cnt <= 0;
         end else begin
            rxb_cnt <= rxb_cnt + 1;
            rxb_sh  <= {rxb_sh[30:0], sdata_b};
         end
      end
   end

   task automatic wait_ready(input bit sel, input string tag);
      for (int i = 0; i < 1000; i++) begin
         if ((sel ? ready_b : ready_a) === 1'b1) return;
         @(posedge clk); #1;
      end
      n_tests++; n_fail++;
      $display("FAIL %s_ready_timeout: ready stayed 0, required 1", tag);
   endtask

   task automatic pulse_send(input bit sel, input logic [31:0] w);
      @(posedge clk); #1;
      if (sel) begin data_b = w; send_b = 1'b1; end else begin data_a = w; send_a = 1'b1; end
      @(posedge clk); #1;
      if (sel) send_b = 1'b0; else send_a = 1'b0;
   endtask

   task automatic get_word(input bit sel, output logic [31:0] w, output bit ok);
      ok = 1'b0;
      w  = 32'hxxxx_xxxx;
      for (int i = 0; i < 2000; i++) begin
         if (sel && rx_b.size() > 0) begin w = rx_b.pop_front(); ok = 1'b1; return; end
         if (!sel && rx_a.size() > 0) begin w = rx_a.pop_front(); ok = 1'b1; return; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic s[8];
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (bclk_a !== 1'b0) begin n_fail++; $display("FAIL rst_bclk: got %b want 0", bclk_a); end
      reset_a = 1'b1; reset_b = 1'b1;
      n_tests++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready_a); end
      n_tests++; if (com_en_a !== 1'b0) begin n_fail++; $display("FAIL rst_com_en: got %b want 0", com_en_a); end
      n_tests++; if (sdata_a !== 1'b0) begin n_fail++; $display("FAIL rst_sdata: got %b want 0", sdata_a); end
      n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done_a); end
      n_tests++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL rst_ready_b: got %b want 1", ready_b); end
      for (int i = 0; i < 8; i++) begin @(posedge clk); #1; s[i] = bclk_a; end
      for (int i = 2; i < 8; i++) begin
         n_tests++;
         if (s[i] !== ~s[i-2]) begin n_fail++; $display("FAIL bclk_toggle[%0d]: got %b want %b", i, s[i], ~s[i-2]); end
      end
   endtask

   task automatic test_single_frame();
      logic [31:0] got, e; bit ok; int d0;
      d0 = done_cnt_a;
      exp_a.push_back(32'hA5A5_0F0F);
      pulse_send(1'b0, 32'hA5A5_0F0F);
      get_word(1'b0, got, ok); e = exp_a.pop_front();
      n_tests++; if (!ok || got !== e) begin n_fail++; $display("FAIL single_word: got %h want %h", got, e); end
      @(posedge clk); #1;
      wait_ready(1'b0, "single");
      @(negedge clk); #1;
      n_tests++; if (last_run_a !== 128) begin n_fail++; $display("FAIL com_en_len: got %0d want 128", last_run_a); end
      n_tests++; if (done_cnt_a - d0 !== 1) begin n_fail++; $display("FAIL done_pulses: got %0d want 1", done_cnt_a - d0); end
      n_tests++; if (rise_a - fall_a !== 8) begin n_fail++; $display("FAIL gap_len: got %0d want 8", rise_a - fall_a); end
      n_tests++; if (coin_a !== 0) begin n_fail++; $display("FAIL done_ready_coincide: got %0d want 0", coin_a); end
   endtask

   task automatic test_loopback();
      logic [31:0] got, e; bit ok;
      wait_ready(1'b0, "loop");
      exp_a.push_back(32'hDEAD_BEEF);
      pulse_send(1'b0, 32'hDEAD_BEEF);
      get_word(1'b0, got, ok); e = exp_a.pop_front();
      n_tests++; if (!ok || got !== e) begin n_fail++; $display("FAIL loopback_word: got %h want %h", got, e); end
   endtask

   task automatic test_busy();
      logic [31:0] got, e; bit ok;
      wait_ready(1'b0, "busy");
      exp_a.push_back(32'hC3C3_3C3C);
      pulse_send(1'b0, 32'hC3C3_3C3C);
      repeat (20) @(posedge clk);
      #1; data_a = 32'h0000_0001; send_a = 1'b1;
      n_tests++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", ready_a); end
      repeat (10) @(posedge clk);
      #1; send_a = 1'b0; data_a = 32'hFFFF_0000;
      get_word(1'b0, got, ok); e = exp_a.pop_front();
      n_tests++; if (!ok || got !== e) begin n_fail++; $display("FAIL busy_word: got %h want %h", got, e); end
      @(posedge clk); #1;
      wait_ready(1'b0, "busy2");
      repeat (12) @(posedge clk);
      #1;
      n_tests++; if (com_en_a !== 1'b0) begin n_fail++; $display("FAIL busy_stray_frame: com_en got %b want 0", com_en_a); end
      n_tests++; if (rx_a.size() !== 0) begin n_fail++; $display("FAIL busy_stray_word: got %0d words want 0", rx_a.size()); end
   endtask

   task automatic test_coincidence();
      logic [31:0] got, e; bit ok; logic prev; int k;
      wait_ready(1'b0, "coin");
      prev = bclk_a;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bclk_a && !prev) break;
         prev = bclk_a;
      end
      @(posedge clk); #1;
      exp_a.push_back(32'h8000_0001);
      data_a = 32'h8000_0001; send_a = 1'b1;
      @(posedge clk); #1;
      send_a = 1'b0;
      n_tests++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL coin_accept: ready got %b want 0", ready_a); end
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (com_en_a) begin k = i; break; end
      end
      n_tests++; if (k !== 4) begin n_fail++; $display("FAIL coin_latency: got %0d want 4", k); end
      n_tests++; if (sdata_a !== 1'b1) begin n_fail++; $display("FAIL coin_first_bit: got %b want 1", sdata_a); end
      get_word(1'b0, got, ok); e = exp_a.pop_front();
      n_tests++; if (!ok || got !== e) begin n_fail++; $display("FAIL coin_word: got %h want %h", got, e); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] got, e; bit ok; bit hit;
      wait_ready(1'b0, "midrst");
      pulse_send(1'b0, 32'hFFFF_FFFF);
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (rxa_cnt == 10) begin hit = 1'b1; break; end
      end
      n_tests++; if (!hit || com_en_a !== 1'b1) begin n_fail++; $display("FAIL midrst_reach_bit10: hit %b com_en %b want 1 1", hit, com_en_a); end
      @(posedge clk); #2;
      reset_a = 1'b0;
      #1;
      n_tests++; if (com_en_a !== 1'b0) begin n_fail++; $display("FAIL midrst_com_en: got %b want 0", com_en_a); end
      n_tests++; if (sdata_a !== 1'b0) begin n_fail++; $display("FAIL midrst_sdata: got %b want 0", sdata_a); end
      n_tests++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", ready_a); end
      repeat (2) @(posedge clk);
      #1; reset_a = 1'b1;
      exp_a.push_back(32'h0000_0001);
      pulse_send(1'b0, 32'h0000_0001);
      get_word(1'b0, got, ok); e = exp_a.pop_front();
      n_tests++; if (!ok || got !== e) begin n_fail++; $display("FAIL midrst_next_word: got %h want %h", got, e); end
   endtask

   task automatic test_back_to_back_gap0();
      logic [31:0] got, e; bit ok;
      exp_b.push_back(32'h1234_5678);
      exp_b.push_back(32'h9ABC_DEF0);
      wait_ready(1'b1, "b2b");
      pulse_send(1'b1, 32'h1234_5678);
      wait_ready(1'b1, "b2b_first");
      n_tests++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL b2b_done_with_ready: got %b want 1", done_b); end
      data_b = 32'h9ABC_DEF0; send_b = 1'b1;
      @(posedge clk); #1;
      send_b = 1'b0;
      for (int j = 0; j < 2; j++) begin
         get_word(1'b1, got, ok); e = exp_b.pop_front();
         n_tests++; if (!ok || got !== e) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", j, got, e); end
      end
      @(posedge clk); #1;
      wait_ready(1'b1, "b2b_second");
      @(negedge clk); #1;
      n_tests++; if (last_low_b !== 4) begin n_fail++; $display("FAIL b2b_low_len: got %0d want 4", last_low_b); end
      n_tests++; if (coin_b !== 2) begin n_fail++; $display("FAIL b2b_coincide: got %0d want 2", coin_b); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_loopback();
      test_busy();
      test_coincidence();
      test_reset_mid_frame();
      test_back_to_back_gap0();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Upstream neighbour of the 32-bit serial receiver. Accepts a parallel word through a valid/ready handshake and shifts it out MSB-first.
- Drives three lines to the receiver:
  - sdata: the data line.
  - com_en: the frame enable; the receiver shifts while it is high and clears while it is low.
  - bclk: a free-running bit clock whose rising edge is the receiver's sampling point.
- Runs entirely on the system clock. No derived clocks are used internally.

Parameters:
- HALF_PERIOD, 51: system-clock cycles per bclk half-period. Bit period is 2*HALF_PERIOD = 102 cycles. Minimum 2.
- WIDTH, 32: bits per frame. Must equal the receiver word width.
- GAP_BITS, 2: idle bit periods with com_en low after each frame. 0 is legal.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset. Low asserts.
- data_in, input, WIDTH: word to transmit. Sampled only on acceptance.
- send, input, 1: data_in valid.
- ready, output, 1: block can accept a word.
- sdata, output, 1: serial data, MSB first.
- com_en, output, 1: frame enable to the receiver.
- bclk, output, 1: bit clock, 50% duty cycle.
- done, output, 1: one-cycle pulse when the last bit period ends.

Behaviour:
- Reset (reset low, asynchronous):
  - phase=0, bclk=0, sdata=0, com_en=0, done=0, ready=1.
  - shreg=0, bitcnt=0, gapcnt=0, state=IDLE.
  - Reset mid-frame drops com_en immediately; the receiver then clears its partial word. No resume after reset.
- Bit timing:
  - phase counter runs 0..2*HALF_PERIOD-1 and wraps, free-running in all states.
  - bclk = (phase >= HALF_PERIOD), registered.
  - Bit boundary strobe = the cycle in which phase wraps to 0.
  - sdata and com_en change only on boundaries, i.e. while bclk is low. They are stable for HALF_PERIOD cycles before each bclk rise.
- FSM states: IDLE, ARMED, SHIFT, GAP.
  - IDLE:
    - ready=1.
    - On send && ready: shreg<=data_in, ready<=0, go to ARMED.
    - Acceptance may occur in any phase.
  - ARMED:
    - Wait for the next boundary.
    - On the boundary: com_en<=1, sdata<=shreg[WIDTH-1], shreg<=shreg<<1, bitcnt<=0, go to SHIFT.
    - If acceptance and a boundary coincide in the same cycle, the frame starts at the following boundary. Worst-case latency from acceptance to first bit is 2*HALF_PERIOD cycles.
  - SHIFT:
    - On each boundary with bitcnt<WIDTH-1: sdata<=shreg[WIDTH-1], shift left, bitcnt++.
    - On the boundary with bitcnt==WIDTH-1:
      - com_en<=0, sdata<=0, done<=1 for one cycle.
      - If GAP_BITS>0: gapcnt<=0, go to GAP.
      - If GAP_BITS==0: go directly to IDLE with ready<=1.
    - com_en is high for exactly WIDTH bit periods. Exactly WIDTH bclk rising edges fall inside the frame.
  - GAP:
    - com_en=0.
    - On each boundary gapcnt++.
    - When gapcnt reaches GAP_BITS-1 on a boundary: go to IDLE, ready<=1.
- send while ready=0 is ignored. data_in changes while busy do not affect the frame in flight.
- done is never high in the same cycle as ready rising, except when GAP_BITS=0, where both occur on the final boundary.
- Back-to-back send: the next frame starts no earlier than GAP_BITS+1 bit periods after the previous com_en fall.
- Width rules:
  - phase counter width = clog2(2*HALF_PERIOD).
  - bitcnt width = clog2(WIDTH).
  - gapcnt width = clog2(GAP_BITS+1).

Decomposition:
- Shared package contains:
  - FSM state encoding (IDLE=0, ARMED=1, SHIFT=2, GAP=3).
  - WORD_WIDTH=32 constant, shared with the receiver.
  - Default HALF_PERIOD=51.
- One natural sub-module: serial_bit_timer. It holds the phase counter and outputs bclk and the boundary strobe (parameter HALF_PERIOD). Top level holds the FSM and shift register.

Test Plan:
1. Reset then idle, HALF_PERIOD=2. Hold reset low 3 cycles, release.
   - Required: ready=1, com_en=0, sdata=0, done=0.
   - Required: bclk toggles every 2 cycles.
2. Single frame. send=1 for one cycle with data_in=32'hA5A5_0F0F.
   - Required: com_en high for exactly 128 cycles (32 periods of 4).
   - Required: sdata sampled on bclk rises reads 1010_0101_1010_0101_0000_1111_0000_1111.
   - Required: done pulses once. ready returns after 2 gap periods.
3. Loopback to the receiver model driven by bclk. Send 32'hDEAD_BEEF.
   - Required: the receiver asserts its ready flag with word 32'hDEAD_BEEF.
4. Busy and coincidence cases.
   - send 32'h1 while ready=0: ignored; the frame in flight is unchanged.
   - Acceptance coinciding with a boundary: first bit appears at the following boundary, 4 cycles later.
5. Reset low in mid-frame, after bit 10 of 32'hFFFF_FFFF.
   - Required: com_en=0 and sdata=0 asynchronously, ready=1.
   - Required: the next 32'h0000_0001 frame transmits correctly.
6. GAP_BITS=0, two back-to-back sends.
   - Required: com_en low for exactly one bit period between frames, done and ready rise in the same cycle.
   - Required: both words received intact.
